// File: rtl/lcd_calc_display.sv
// Accumulator calculator with an HD44780-style LCD writer: powers up the panel,
// then clears it or shows the accumulator as hex on request.
module lcd_calc_display #(
    parameter int WIDTH        = 8,
    parameter int POR_CYC      = 750000,
    parameter int EN_PULSE_CYC = 25,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 80000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] op_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy,
    output logic [7:0]       lcd_data,
    output logic             lcd_rs,
    output logic             lcd_en
);

    localparam int MAX_AB  = (POR_CYC > CLR_WAIT_CYC) ? POR_CYC : CLR_WAIT_CYC;
    localparam int MAX_CD  = (CMD_WAIT_CYC > EN_PULSE_CYC) ? CMD_WAIT_CYC : EN_PULSE_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int NIBBLES = WIDTH / 4;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_DEC   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_DISP  = 3'b111;

    typedef enum logic [2:0] {S_POR, S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
    typedef enum logic [1:0] {SEQ_INIT, SEQ_CLEAR, SEQ_DISP} seq_t;

    state_t           state_q, state_d;
    seq_t             seq_q, seq_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] snap_q, snap_d;

    logic             byte_rs;
    logic [7:0]       byte_data;
    logic             last_byte;
    logic [WIDTH-1:0] shifted;
    logic [3:0]       nib;
    logic [CNT_W-1:0] hold_last;
    logic             in_write;

    // Byte currently being written, derived from the active sequence and its index.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        byte_rs   = 1'b0;
        byte_data = 8'h00;
        last_byte = 1'b1;
        shifted   = '0;
        nib       = 4'h0;
        case (seq_q)
            SEQ_INIT: begin
                last_byte = (idx_q == 3'd3);
                case (idx_q)
                    3'd0:    byte_data = 8'h38;
                    3'd1:    byte_data = 8'h0C;
                    3'd2:    byte_data = 8'h01;
                    default: byte_data = 8'h06;
                endcase
            end
            SEQ_CLEAR: byte_data = 8'h01;
            SEQ_DISP: begin
                last_byte = (idx_q == 3'(NIBBLES));
                if (idx_q == 3'd0) begin
                    byte_data = 8'h80;
                end else begin
                    byte_rs   = 1'b1;
                    shifted   = snap_q >> (WIDTH - 4 * int'(idx_q));
                    nib       = shifted[3:0];
                    byte_data = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
                end
            end
            default: byte_data = 8'h00;
        endcase
    end

    assign hold_last = (!byte_rs && (byte_data == 8'h01 || byte_data == 8'h02))
                       ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        case (state_q)
            S_POR: begin
                if (cnt_q == CNT_W'(POR_CYC - 1)) begin
                    state_d = S_SETUP;
                    seq_d   = SEQ_INIT;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (op_valid) begin
                    case (opcode)
                        OP_LOAD: acc_d = op_in;
                        OP_ADD:  acc_d = acc_q + op_in;
                        OP_INC:  acc_d = acc_q + WIDTH'(1);
                        OP_SUB:  acc_d = acc_q - op_in;
                        OP_DEC:  acc_d = acc_q - WIDTH'(1);
                        OP_MUL:  acc_d = acc_q * op_in;
                        OP_CLEAR: begin
                            acc_d   = '0;
                            seq_d   = SEQ_CLEAR;
                            idx_d   = 3'd0;
                            state_d = S_SETUP;
                        end
                        OP_DISP: begin
                            snap_d  = acc_q;
                            seq_d   = SEQ_DISP;
                            idx_d   = 3'd0;
                            state_d = S_SETUP;
                        end
                        default: acc_d = acc_q;
                    endcase
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(EN_PULSE_CYC - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == hold_last) begin
                    cnt_d = '0;
                    if (last_byte) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_POR;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_POR;
            seq_q   <= SEQ_INIT;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            acc_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            snap_q  <= snap_d;
        end
    end

    assign in_write = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);
    assign op_ready = (state_q == S_IDLE);
    assign busy     = ~op_ready;
    assign lcd_en   = (state_q == S_PULSE);
    assign lcd_rs   = in_write & byte_rs;
    assign lcd_data = in_write ? byte_data : 8'h00;
    assign acc_out  = acc_q;

endmodule

// File: tb/tb_lcd_calc_display.sv
// Directed bench for lcd_calc_display: init sequence, arithmetic, DISPLAY/CLEAR
// byte streams and reset abort, all with hand-computed expectations.
module tb_lcd_calc_display;

    localparam int WIDTH        = 8;
    localparam int POR_CYC      = 10;
    localparam int EN_PULSE_CYC = 2;
    localparam int CMD_WAIT_CYC = 4;
    localparam int CLR_WAIT_CYC = 8;
    // First IDLE cycle after reset release: POR wait plus 3 normal and 1 clear-length writes.
    localparam int INIT_READY = POR_CYC + 4 * (1 + EN_PULSE_CYC) + 3 * CMD_WAIT_CYC + CLR_WAIT_CYC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       opcode = 3'b000;
    logic [WIDTH-1:0] op_in = '0;
    logic [WIDTH-1:0] acc_out;
    logic             busy;
    logic [7:0]       lcd_data;
    logic             lcd_rs;
    logic             lcd_en;

    lcd_calc_display #(
        .WIDTH(WIDTH), .POR_CYC(POR_CYC), .EN_PULSE_CYC(EN_PULSE_CYC),
        .CMD_WAIT_CYC(CMD_WAIT_CYC), .CLR_WAIT_CYC(CLR_WAIT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .op_in(op_in), .acc_out(acc_out), .busy(busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] pd [8];
    logic       pr [8];
    int         pl [8];
    int         np;
    int         ready_at;
    logic [7:0] init_exp [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples once per falling edge starting in the current cycle (k=1), logging each
    // lcd_en pulse and the first cycle op_ready is high. Drops op_valid after one cycle.
    task automatic capture(input int budget);
        logic prev_en;
        prev_en  = 1'b0;
        np       = 0;
        ready_at = -1;
        for (int k = 1; k <= budget; k++) begin
            if (lcd_en && !prev_en) begin
                if (np < 8) begin
                    pd[np] = lcd_data;
                    pr[np] = lcd_rs;
                    pl[np] = 1;
                end
                np++;
            end else if (lcd_en && np > 0 && np <= 8) begin
                pl[np-1]++;
            end
            if (op_ready) begin
                ready_at = k;
                break;
            end
            prev_en = lcd_en;
            @(negedge clk);
            op_valid = 1'b0;
        end
    endtask

    task automatic do_op(input logic [2:0] opc, input logic [WIDTH-1:0] val);
        op_valid = 1'b1;
        opcode   = opc;
        op_in    = val;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic init_check(input string tag);
        capture(200);
        check({tag, "_pulses"}, np, 4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_data"}, pd[i], init_exp[i]);
            check({tag, "_rs"}, pr[i], 1'b0);
            check({tag, "_len"}, pl[i], EN_PULSE_CYC);
        end
        check({tag, "_ready_at"}, ready_at, INIT_READY);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_acc", acc_out, 8'h00);
        check("rst_ready", op_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_en", lcd_en, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_data", lcd_data, 8'h00);

        rst_n = 1'b1;
        @(negedge clk);
        init_check("init");

        do_op(3'b000, 8'h12); check("load12", acc_out, 8'h12); check("rdy1", op_ready, 1'b1);
        do_op(3'b001, 8'h34); check("add34", acc_out, 8'h46); check("rdy2", op_ready, 1'b1);
        do_op(3'b101, 8'h03); check("mul03", acc_out, 8'hD2); check("rdy3", op_ready, 1'b1);

        do_op(3'b000, 8'hFF); check("loadFF", acc_out, 8'hFF);
        do_op(3'b010, 8'h00); check("inc_wrap", acc_out, 8'h00);
        do_op(3'b100, 8'h00); check("dec_wrap", acc_out, 8'hFF);
        do_op(3'b000, 8'h00); check("load00", acc_out, 8'h00);
        do_op(3'b011, 8'h01); check("sub_wrap", acc_out, 8'hFF);

        do_op(3'b000, 8'hD2);
        do_op(3'b111, 8'h00);
        check("disp_ready_low", op_ready, 1'b0);
        check("disp_busy", busy, 1'b1);
        op_valid = 1'b1;
        opcode   = 3'b001;
        op_in    = 8'h11;
        capture(200);
        check("disp_pulses", np, 3);
        check("disp_b0_rs", pr[0], 1'b0); check("disp_b0", pd[0], 8'h80);
        check("disp_b1_rs", pr[1], 1'b1); check("disp_b1", pd[1], 8'h44);
        check("disp_b2_rs", pr[2], 1'b1); check("disp_b2", pd[2], 8'h32);
        for (int i = 0; i < 3; i++) check("disp_len", pl[i], EN_PULSE_CYC);
        check("disp_ready_at", ready_at, 3 * (1 + EN_PULSE_CYC + CMD_WAIT_CYC) + 1);
        check("disp_acc_kept", acc_out, 8'hD2);

        do_op(3'b000, 8'h5A); check("load5A", acc_out, 8'h5A);
        do_op(3'b110, 8'h00);
        check("clr_acc", acc_out, 8'h00);
        capture(200);
        check("clr_pulses", np, 1);
        check("clr_data", pd[0], 8'h01);
        check("clr_rs", pr[0], 1'b0);
        check("clr_len", pl[0], EN_PULSE_CYC);
        check("clr_ready_at", ready_at, 1 + EN_PULSE_CYC + CLR_WAIT_CYC + 1);

        do_op(3'b000, 8'hD2);
        do_op(3'b111, 8'h00);
        repeat (1 + EN_PULSE_CYC + CMD_WAIT_CYC + 1) @(negedge clk);
        check("abort_pre_en", lcd_en, 1'b1);
        check("abort_pre_data", lcd_data, 8'h44);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_en", lcd_en, 1'b0);
        check("abort_acc", acc_out, 8'h00);
        check("abort_ready", op_ready, 1'b0);
        check("abort_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        init_check("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
